// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - multicycle Moore control unit for the 8-bit stack-machine datapath
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   opcode[2:0]       IR[7:5] from the datapath
//   pcWrite .. tos    single-bit datapath control strobes
//   ALUOp[1:0]        00 add, 01 sub, 10 and, 11 not
//   state[3:0]        current state encoding (debug)
//   instr_done        high during the final cycle of every instruction

module stack_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       pcSrc,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       MtoS,
    output logic       ldA,
    output logic       ldB,
    output logic       srcA,
    output logic       srcB,
    output logic       push,
    output logic       pop,
    output logic       tos,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_POP_A   = 4'd2,
        S_POP_B   = 4'd3,
        S_EXEC    = 4'd4,
        S_WB      = 4'd5,
        S_MEM_RD  = 4'd6,
        S_PUSH_WB = 4'd7,
        S_MEM_WR  = 4'd8,
        S_JMP     = 4'd9,
        S_JZ_TOS  = 4'd10,
        S_JZ_BR   = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    // ALU function is latched in ID so the EXEC output depends on state
    // registers only, keeping the machine strictly Moore.
    logic [1:0] r_alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IF;
            r_alu_op <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID) begin
                r_alu_op <= opcode[1:0];
            end
        end
    end

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF: w_next = S_ID;
            S_ID: begin
                case (opcode)
                    3'b100:  w_next = S_MEM_RD;
                    3'b110:  w_next = S_JMP;
                    3'b111:  w_next = S_JZ_TOS;
                    default: w_next = S_POP_A;
                endcase
            end
            S_POP_A: begin
                case (opcode)
                    3'b011:  w_next = S_EXEC;
                    3'b101:  w_next = S_MEM_WR;
                    default: w_next = S_POP_B;
                endcase
            end
            S_POP_B:   w_next = S_EXEC;
            S_EXEC:    w_next = S_WB;
            S_MEM_RD:  w_next = S_PUSH_WB;
            S_JZ_TOS:  w_next = S_JZ_BR;
            // WB, PUSH_WB, MEM_WR, JMP, JZ_BR and unused encodings return to fetch
            default:   w_next = S_IF;
        endcase
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSrc       = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        MtoS        = 1'b0;
        ldA         = 1'b0;
        ldB         = 1'b0;
        srcA        = 1'b0;
        srcB        = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        tos         = 1'b0;
        ALUOp       = 2'b00;
        instr_done  = 1'b0;
        case (r_state)
            S_IF: begin
                // IR load and PC <= PC + 1 share this edge
                memRead = 1'b1;
                IRWrite = 1'b1;
                srcA    = 1'b1;
                srcB    = 1'b1;
                pcWrite = 1'b1;
            end
            S_POP_A: begin
                pop = 1'b1;
                ldA = 1'b1;
            end
            S_POP_B: begin
                pop = 1'b1;
                ldB = 1'b1;
            end
            S_EXEC:  ALUOp = r_alu_op;
            S_WB: begin
                push       = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                memRead = 1'b1;
            end
            S_PUSH_WB: begin
                MtoS       = 1'b1;
                push       = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                IorD       = 1'b1;
                memWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JMP: begin
                pcSrc      = 1'b1;
                pcWrite    = 1'b1;
                instr_done = 1'b1;
            end
            S_JZ_TOS: tos = 1'b1;
            S_JZ_BR: begin
                // branch qualification by Z happens in the datapath
                pcSrc       = 1'b1;
                pcWriteCond = 1'b1;
                instr_done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = r_state;

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Multicycle Moore control unit for the 8-bit stack-machine datapath; sits directly upstream of it.
- Receives the 3-bit opcode (IR[7:5]) and drives every datapath control strobe: pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS, ldA, ldB, srcA, srcB, push, pop, tos, ALUOp.
- Sequences fetch, decode and per-instruction execute cycles; exports state and an end-of-instruction pulse for debug and verification.

Parameters:
- None. State width is fixed at 4 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  3  IR[7:5] from datapath
- pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS  out  1 each  datapath strobes
- ldA, ldB, srcA, srcB, push, pop, tos  out  1 each  datapath strobes
- ALUOp  out  2  00 add, 01 sub, 10 and, 11 not
- state  out  4  current state encoding
- instr_done  out  1  high during the final cycle of every instruction

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr.
- Pure Moore machine. Outputs are decoded from state only; any strobe not listed for a state is 0.
- Default ALUOp is 00 except in EXEC.
- Reset: state <= IF asynchronously. While rst is high, outputs show IF values. Reset mid-instruction abandons it; no partial-state carryover.
- States (encoding, outputs -> next state):
  - IF (0): memRead, IorD=0, IRWrite, srcA=1, srcB=1, ALUOp=00, pcSrc=0, pcWrite -> ID. IR is loaded and PC becomes PC+1 at the same edge.
  - ID (1): no strobes. Next state by opcode:
    - 000/001/010/011/101 -> POP_A
    - 100 -> MEM_RD
    - 110 -> JMP
    - 111 -> JZ_TOS
  - POP_A (2): pop, ldA.
    - opcode 000/001/010 -> POP_B
    - 011 -> EXEC
    - 101 -> MEM_WR
  - POP_B (3): pop, ldB -> EXEC.
  - EXEC (4): srcA=0, srcB=0, ALUOp=opcode[1:0]. ALU result register captures at the edge -> WB.
  - WB (5): MtoS=0, push, instr_done -> IF.
  - MEM_RD (6): IorD=1, memRead. MDR captures -> PUSH_WB.
  - PUSH_WB (7): MtoS=1, push, instr_done -> IF.
  - MEM_WR (8): IorD=1, memWrite (data = A), instr_done -> IF.
  - JMP (9): pcSrc=1, pcWrite, instr_done -> IF.
  - JZ_TOS (10): tos. Z captures top-of-stack; stack is not popped -> JZ_BR.
  - JZ_BR (11): pcSrc=1, pcWriteCond, instr_done -> IF. The branch qualification itself is done in the datapath.
  - Encodings 12-15: all strobes 0 -> IF (recovery).
- Cycle counts, IF through final state inclusive:
  - ADD/SUB/AND: 6
  - NOT: 5
  - PUSH: 4
  - POP: 4
  - JMP: 3
  - JZ: 4
- Invariants:
  - push and pop are never asserted in the same state.
  - memRead and memWrite are never asserted together.
  - pcWrite and pcWriteCond are never asserted together.
  - instr_done is high for exactly one cycle per instruction.
- Opcode is sampled only in ID and POP_A. IR is stable after IF, so opcode changes in other states have no effect.

Test Plan:
- rst=1 asynchronously mid-cycle while in EXEC -> state=0 immediately. Outputs: memRead=1, IRWrite=1, pcWrite=1, srcA=1, srcB=1; all others 0. After release, state advances 0->1.
- opcode=001 (SUB) -> state trace 0,1,2,3,4,5,0. ldA in cycle 2, ldB in cycle 3, ALUOp=01 only in cycle 4, push and instr_done in cycle 5.
- opcode=011 (NOT) -> trace 0,1,2,4,5,0. ALUOp=11 in EXEC; ldB never asserted.
- opcode=100 (PUSH) -> trace 0,1,6,7,0. IorD=1 and memRead=1 in state 6; MtoS=1 and push=1 in state 7. opcode=101 (POP) -> trace 0,1,2,8,0 with memWrite=1 only in state 8.
- opcode=110 (JMP) -> trace 0,1,9,0 with pcSrc=1, pcWrite=1. opcode=111 (JZ) -> trace 0,1,10,11,0 with tos=1 in state 10, pcWriteCond=1 in state 11, pop=0 throughout.
- Random 1000-instruction opcode stream -> invariants hold every cycle. instr_done pulse count equals instruction count, and cycle totals match the per-opcode counts.
